pipe_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the fixed hazard-detect/forwarding pair. Tracks the in-flight

---
 rtl/arm_pipe_pkg.sv | 20 ++
 rtl/pipe_hazard_scoreboard_if.sv | 38 +++
 rtl/pipe_sb_match.sv | 36 +++
 rtl/pipe_hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// An entry records one in-flight register write behind the decode stage.
package arm_pipe_pkg;

    localparam int RA_W_DEF   = 4;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                vld;
        logic                wb_en;
        logic                mem_read;
        logic [RA_W_DEF-1:0] dest;
    } sb_entry_t;

    // True when the entry is a live register write to the given address.
    function automatic logic sb_hit(input sb_entry_t e, input logic [RA_W_DEF-1:0] src);
        return e.vld & e.wb_en & (e.dest == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side and EXE-side signals of the hazard scoreboard.
// The pipeline control (master) drives instruction fields; the scoreboard (slave) answers.
interface pipe_hazard_scoreboard_if
    import arm_pipe_pkg::*;
#(
    parameter int RA_W    = RA_W_DEF,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(DEPTH);

    logic                    id_valid;
    logic                    id_wb_en;
    logic                    id_mem_read;
    logic [RA_W-1:0]         id_dest;
    logic [NUM_SRC*RA_W-1:0] id_src;
    logic [NUM_SRC-1:0]      id_src_vld;
    logic                    fwd_en;
    logic                    freeze_ext;
    logic                    flush;
    logic                    stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output id_valid, id_wb_en, id_mem_read, id_dest, id_src, id_src_vld,
        output fwd_en, freeze_ext, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_wb_en, id_mem_read, id_dest, id_src, id_src_vld,
        input  fwd_en, freeze_ext, flush,
        output stall, fwd_sel, stall_cnt
    );

endinterface

// File: rtl/pipe_sb_match.sv
// Compares one source register against the tracked entries and returns the youngest hit.
// MIN_K skips the youngest stages; loads younger than LOAD_MIN are not eligible.
module pipe_sb_match
    import arm_pipe_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int MIN_K    = 0,
    parameter int LOAD_MIN = 0,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic [RA_W_DEF-1:0]   src,
    input  logic                  src_vld,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic                  hit,
    output logic [SEL_W-1:0]      idx,
    output logic                  is_load
);

    logic match_s;

    // Scan oldest to youngest so the youngest eligible match overwrites the result last.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        match_s = 1'b0;
        for (int k = DEPTH - 1; k >= MIN_K; k--) begin
            match_s = src_vld & sb_hit(entries[k], src)
                      & (~entries[k].mem_read | (k >= LOAD_MIN));
            hit     = hit | match_s;
            idx     = match_s ? SEL_W'(k) : idx;
            is_load = match_s ? entries[k].mem_read : is_load;
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Load-use / writeback hazard scoreboard: tracks DEPTH post-decode register writes,
// stalls the decode instruction when needed and selects forwarding sources for EXE.
module pipe_hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter int RA_W     = RA_W_DEF,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input logic                     clk,
    input logic                     rst,
    pipe_hazard_scoreboard_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0]    entry_r;
    logic [NUM_SRC*RA_W-1:0]  exe_src_r;
    logic [NUM_SRC-1:0]       exe_src_vld_r;
    logic [CNT_W-1:0]         stall_cnt_r;

    logic [NUM_SRC-1:0]       id_hit_s;
    logic [NUM_SRC-1:0]       id_load_s;
    logic [SEL_W-1:0]         id_idx_s [NUM_SRC];
    logic [NUM_SRC-1:0]       exe_hit_s;
    logic [NUM_SRC-1:0]       exe_load_s;
    logic [SEL_W-1:0]         exe_idx_s [NUM_SRC];

    logic                     stall_raw_s;
    logic                     stall_s;
    logic                     take_s;
    sb_entry_t                id_entry_s;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;

    // The decode-side lookup sees every stage; the EXE-side lookup starts at MEM.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        pipe_sb_match #(
            .DEPTH    (DEPTH),
            .MIN_K    (0),
            .LOAD_MIN (0),
            .SEL_W    (SEL_W)
        ) u_id_match (
            .src     (bus.id_src[i*RA_W +: RA_W]),
            .src_vld (bus.id_src_vld[i]),
            .entries (entry_r),
            .hit     (id_hit_s[i]),
            .idx     (id_idx_s[i]),
            .is_load (id_load_s[i])
        );

        pipe_sb_match #(
            .DEPTH    (DEPTH),
            .MIN_K    (1),
            .LOAD_MIN (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_exe_match (
            .src     (exe_src_r[i*RA_W +: RA_W]),
            .src_vld (exe_src_vld_r[i]),
            .entries (entry_r),
            .hit     (exe_hit_s[i]),
            .idx     (exe_idx_s[i]),
            .is_load (exe_load_s[i])
        );
    end

    // Raw hazard: with forwarding only an unready load stalls, otherwise any write not yet in WB.
    always_comb begin
        stall_raw_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.fwd_en) begin
                stall_raw_s = stall_raw_s | (id_hit_s[i] & id_load_s[i]
                              & ((int'(id_idx_s[i]) + 1) < LOAD_LAT));
            end else begin
                stall_raw_s = stall_raw_s | (id_hit_s[i]
                              & (int'(id_idx_s[i]) < (DEPTH - 1)));
            end
        end
    end

    // A flushed or empty decode slot never stalls and never enters the table.
    always_comb begin
        stall_s    = bus.id_valid & ~bus.flush & stall_raw_s;
        take_s     = bus.id_valid & ~stall_s & ~bus.flush;
        id_entry_s = '0;
        if (take_s) begin
            id_entry_s.vld      = 1'b1;
            id_entry_s.wb_en    = bus.id_wb_en;
            id_entry_s.mem_read = bus.id_mem_read;
            id_entry_s.dest     = bus.id_dest;
        end else begin
            id_entry_s.vld      = 1'b0;
        end
    end

    // Forwarding select per source for the instruction currently in EXE.
    always_comb begin
        fwd_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.fwd_en && exe_hit_s[i]
                && (!exe_load_s[i] || (int'(exe_idx_s[i]) >= LOAD_LAT))) begin
                fwd_sel_s[i*SEL_W +: SEL_W] = exe_idx_s[i];
            end else begin
                fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
            end
        end
    end

    // Entry shift register, EXE source latch and saturating stall counter; freeze holds all.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_r       <= '0;
            exe_src_r     <= '0;
            exe_src_vld_r <= '0;
            stall_cnt_r   <= '0;
        end else if (!bus.freeze_ext) begin
            entry_r       <= {entry_r[DEPTH-2:0], id_entry_s};
            exe_src_r     <= take_s ? bus.id_src : exe_src_r;
            exe_src_vld_r <= take_s ? bus.id_src_vld : {NUM_SRC{1'b0}};
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall_s;
    assign bus.fwd_sel   = fwd_sel_s;
    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed table-driven bench for pipe_hazard_scoreboard with hand-written
// sequences for flush, freeze, mid-run reset and counter saturation.
module tb_pipe_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.RA_W(4), .NUM_SRC(2), .DEPTH(3), .CNT_W(4)) bus ();

    pipe_hazard_scoreboard #(
        .RA_W(4), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(2), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       v;
        logic       wb;
        logic       ld;
        logic [3:0] dest;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] sv;
        logic       fe;
        logic       fr;
        logic       fl;
        logic       es;
        logic [3:0] esel;
        logic [3:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic wb, input logic ld,
                                input logic [3:0] dest, input logic [3:0] s0,
                                input logic [3:0] s1, input logic [1:0] sv,
                                input logic fe, input logic fr, input logic fl,
                                input logic es, input logic [3:0] esel,
                                input logic [3:0] ecnt);
        vec_t t;
        t.v = v; t.wb = wb; t.ld = ld; t.dest = dest; t.s0 = s0; t.s1 = s1;
        t.sv = sv; t.fe = fe; t.fr = fr; t.fl = fl; t.es = es;
        t.esel = esel; t.ecnt = ecnt;
        return t;
    endfunction

    function automatic vec_t idle(input logic fe, input logic [3:0] esel, input logic [3:0] ecnt);
        return mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, fe, 1'b0, 1'b0, 1'b0, esel, ecnt);
    endfunction

    task automatic check(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid    = t.v;
        bus.id_wb_en    = t.wb;
        bus.id_mem_read = t.ld;
        bus.id_dest     = t.dest;
        bus.id_src      = {t.s1, t.s0};
        bus.id_src_vld  = t.sv;
        bus.fwd_en      = t.fe;
        bus.freeze_ext  = t.fr;
        bus.flush       = t.fl;
    endtask

    task automatic apply(input vec_t t, input int id);
        drive(t);
        @(negedge clk);
        check("stall", id, 16'(bus.stall), 16'(t.es));
        check("fwd_sel", id, 16'(bus.fwd_sel), 16'(t.esel));
        check("stall_cnt", id, 16'(bus.stall_cnt), 16'(t.ecnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ns;
        vec_t t;

        drive(idle(1'b1, 4'd0, 4'd0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 0, 16'(bus.stall), 16'd0);
        check("rst_fwd_sel", 0, 16'(bus.fwd_sel), 16'd0);
        check("rst_stall_cnt", 0, 16'(bus.stall_cnt), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU chain forwarded from MEM
        tbl.push_back(mk(1, 1, 0, 4'd1, 4'd8, 4'd9,  2'b11, 1, 0, 0, 0, 4'b0000, 4'd0));
        tbl.push_back(mk(1, 1, 0, 4'd2, 4'd1, 4'd10, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd0));
        tbl.push_back(idle(1'b1, 4'b0001, 4'd0));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd0));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd0));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd0));
        // load-use: one stall, then forward from WB
        tbl.push_back(mk(1, 1, 1, 4'd3, 4'd11, 4'd0, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd0));
        tbl.push_back(mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 0, 0, 1, 4'b0000, 4'd0));
        tbl.push_back(mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd1));
        tbl.push_back(idle(1'b1, 4'b0010, 4'd1));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd1));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd1));
        // no forwarding: stall until producer reaches WB
        tbl.push_back(mk(1, 1, 0, 4'd1, 4'd8, 4'd9,  2'b11, 0, 0, 0, 0, 4'b0000, 4'd1));
        tbl.push_back(mk(1, 1, 0, 4'd5, 4'd1, 4'd13, 2'b11, 0, 0, 0, 1, 4'b0000, 4'd1));
        tbl.push_back(mk(1, 1, 0, 4'd5, 4'd1, 4'd13, 2'b11, 0, 0, 0, 1, 4'b0000, 4'd2));
        tbl.push_back(mk(1, 1, 0, 4'd5, 4'd1, 4'd13, 2'b11, 0, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b0, 4'b0000, 4'd3));
        // youngest producer wins on both sources
        tbl.push_back(mk(1, 1, 0, 4'd1, 4'd8, 4'd9,  2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 0, 4'd1, 4'd14, 4'd0, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 0, 4'd6, 4'd1, 4'd1,  2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0101, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        // forwarding disabled while the consumer sits in EXE
        tbl.push_back(mk(1, 1, 0, 4'd7, 4'd8, 4'd9, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 0, 4'd2, 4'd9, 4'd7, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        // same chain with forwarding: source 1 selects MEM
        tbl.push_back(mk(1, 1, 0, 4'd7, 4'd8, 4'd9, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 0, 4'd2, 4'd9, 4'd7, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0100, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        // unused source operand never forwards nor stalls
        tbl.push_back(mk(1, 1, 0, 4'd3, 4'd8, 4'd9, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 0, 4'd4, 4'd12, 4'd3, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 1, 4'd3, 4'd11, 4'd0, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(mk(1, 1, 0, 4'd4, 4'd12, 4'd3, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));
        tbl.push_back(idle(1'b1, 4'b0000, 4'd3));

        foreach (tbl[i]) apply(tbl[i], i + 1);

        // flush beats a pending load-use stall; the killed ADD r4 must not enter the table
        apply(mk(1, 1, 1, 4'd3, 4'd11, 4'd0, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd3), 100);
        apply(mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 0, 1, 0, 4'b0000, 4'd3), 101);
        apply(mk(1, 0, 0, 4'd0, 4'd4, 4'd0,  2'b01, 0, 0, 0, 0, 4'b0000, 4'd3), 102);
        apply(idle(1'b1, 4'b0000, 4'd3), 103);
        apply(idle(1'b1, 4'b0000, 4'd3), 104);

        // freeze for three cycles during a load-use stall
        apply(mk(1, 1, 1, 4'd3, 4'd11, 4'd0, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd3), 200);
        for (int k = 0; k < 3; k++)
            apply(mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 1, 0, 1, 4'b0000, 4'd3), 201 + k);
        apply(mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 0, 0, 1, 4'b0000, 4'd3), 204);
        apply(mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd4), 205);
        apply(idle(1'b1, 4'b0010, 4'd4), 206);
        apply(idle(1'b1, 4'b0000, 4'd4), 207);
        apply(idle(1'b1, 4'b0000, 4'd4), 208);

        // reset while a stall is pending clears the table and the counter
        apply(mk(1, 1, 1, 4'd3, 4'd11, 4'd0, 2'b01, 1, 0, 0, 0, 4'b0000, 4'd4), 300);
        t = mk(1, 1, 0, 4'd4, 4'd3, 4'd12, 2'b11, 1, 0, 0, 0, 4'b0000, 4'd0);
        drive(t);
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_stall", 301, 16'(bus.stall), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(t, 302);

        // repeated self-dependency without forwarding: stall 2 of every 3 cycles, counter saturates
        ns = 0;
        for (int i = 0; i < 30; i++) begin
            t = mk(1, 1, 0, 4'd1, 4'd1, 4'd0, 2'b01, 0, 0, 0, ((i % 3) != 0),
                   4'b0000, 4'((ns > 15) ? 15 : ns));
            apply(t, 400 + i);
            if ((i % 3) != 0) ns++;
        end
        apply(idle(1'b0, 4'b0000, 4'd15), 430);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
